// File: rtl/add_seq_7bit.sv
// add_seq_7bit: runs a WORDS-chunk addition through an external WIDTH-bit adder, one chunk per cycle
module add_seq_7bit #(
    parameter int WIDTH = 7,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    input  logic                   in_cin,
    output logic [WIDTH-1:0]       fa_a,
    output logic [WIDTH-1:0]       fa_b,
    output logic                   fa_cin,
    input  logic [WIDTH-1:0]       fa_s,
    input  logic                   fa_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_sum,
    output logic                   out_cout,
    output logic                   busy
);
    localparam int N  = WIDTH * WORDS;
    localparam int KW = WORDS > 1 ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [KW-1:0] k;
    logic [N-1:0] a_sh, b_sh, part;
    logic carry;
    logic last;
    logic [N+WIDTH-1:0] part_cat;
    assign last     = k == KW'(WORDS - 1);
    assign part_cat = {fa_s, part};
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign fa_a   = a_sh[WIDTH-1:0];
    assign fa_b   = b_sh[WIDTH-1:0];
    assign fa_cin = carry;
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // Next state: accept in IDLE, leave RUN after the last chunk, release DONE on handshake
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE)
                 : state == RUN  ? (last ? DONE : RUN)
                 : (out_ready ? IDLE : DONE);
    end
    // Datapath: operands shift down one chunk per cycle and drain to zero, so fa_* read 0 outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            part     <= '0;
            carry    <= 1'b0;
            k        <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            k     <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> WIDTH;
            b_sh  <= b_sh >> WIDTH;
            part  <= part_cat[N+WIDTH-1:WIDTH];
            carry <= last ? 1'b0 : fa_cout;
            k     <= k + 1'b1;
            if (last) begin
                out_sum  <= part_cat[N+WIDTH-1:WIDTH];
                out_cout <= fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_add_seq_7bit.sv
// tb_add_seq_7bit: scoreboard bench for add_seq_7bit with a behavioural 7-bit adder attached
module tb_add_seq_7bit;
    localparam int W = 7;
    localparam int WORDS = 4;
    localparam int N = W * WORDS;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
    logic [N-1:0] in_a = '0, in_b = '0;
    logic in_ready, fa_cin, fa_cout, out_valid, out_cout, busy;
    logic [W-1:0] fa_a, fa_b, fa_s;
    logic [N-1:0] out_sum;
    int tests = 0, fails = 0, n_sent = 0, n_got = 0, n_abort = 0;
    logic [N:0] q[$];
    logic [N:0] e;
    bit done = 0;

    add_seq_7bit #(.WIDTH(W), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .busy(busy)
    );

    assign {fa_cout, fa_s} = {1'b0, fa_a} + {1'b0, fa_b} + {7'd0, fa_cin};

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed 0");
        end else begin
            q.push_back({1'b0, a} + {1'b0, b} + {{N{1'b0}}, c});
            n_sent++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready && q.size() == 0;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL idle_timeout: in_ready=%0b pending=%0d", in_ready, q.size());
        end
    endtask

    // Monitor: every result handshake pops one expected value in order
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL result_extra: got 0x%0h with nothing expected", {out_cout, out_sum});
            end else begin
                e = q.pop_front();
                chk("result", {3'b0, out_cout, out_sum}, {3'b0, e});
                n_got++;
            end
        end
    end

    initial begin
        int n;
        bit ok;
        logic [3:0] exp_c;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fa_a", 32'(fa_a), 0);
        chk("rst_fa_cin", 32'(fa_cin), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_cout", 32'(out_cout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);

        out_ready = 1'b1;
        send(28'h0000001, 28'h0000001, 1'b0);
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            @(negedge clk);
            if (out_valid) n = i;
        end
        chk("t2_latency_edges", 32'(n - 1), 4);
        chk("t2_in_ready_done", 32'(in_ready), 0);
        @(negedge clk);
        chk("t2_in_ready_after", 32'(in_ready), 1);
        chk("t2_out_valid_after", 32'(out_valid), 0);
        chk("t2_busy_after", 32'(busy), 0);

        send(28'hFFFFFFF, 28'h0000001, 1'b0);
        exp_c = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t3_fa_cin_%0d", i), 32'(fa_cin), 32'(exp_c[i]));
        end
        wait_idle();

        send(28'h000007F, 28'h0000000, 1'b1);
        @(negedge clk);
        chk("t4_fa_a", 32'(fa_a), 32'h7F);
        chk("t4_fa_cin", 32'(fa_cin), 1);
        chk("t4_fa_s", 32'(fa_s), 0);
        chk("t4_fa_cout", 32'(fa_cout), 1);
        wait_idle();

        out_ready = 1'b0;
        send(28'h0000010, 28'h0000020, 1'b0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        chk("t5_out_valid_rise", 32'(ok), 1);
        @(posedge clk);
        #1;
        in_a = 28'h1111111; in_b = 28'h2222222; in_cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 32'(out_valid), 1);
            chk("t5_hold_sum", 32'(out_sum), 32'h30);
            chk("t5_hold_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_idle_in_ready", 32'(in_ready), 1);
        q.push_back(29'h3333334);
        n_sent++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t5_accepted_busy", 32'(busy), 1);
        wait_idle();

        send(28'h1234567, 28'h7654321, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t1_chunk2_fa_a", 32'(fa_a), 32'h0D);
        chk("t1_chunk2_fa_b", 32'(fa_b), 32'h15);
        rst_n = 1'b0;
        #1;
        chk("t1_abort_out_valid", 32'(out_valid), 0);
        chk("t1_abort_busy", 32'(busy), 0);
        chk("t1_abort_fa_a", 32'(fa_a), 0);
        chk("t1_abort_fa_b", 32'(fa_b), 0);
        chk("t1_abort_fa_cin", 32'(fa_cin), 0);
        chk("t1_abort_out_sum", 32'(out_sum), 0);
        q.delete();
        n_abort++;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_release_in_ready", 32'(in_ready), 1);
        send(28'h0000005, 28'h0000003, 1'b0);
        wait_idle();

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    send(N'($urandom()), N'($urandom()), 1'($urandom()));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        chk("t6_queue_empty", 32'(q.size()), 0);
        chk("t6_result_count", 32'(n_got), 32'(n_sent - n_abort));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
